// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, register indices and typedefs
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP = 5'd29;
  localparam word_t SP_INIT = 32'h0000_03FC;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read port with $0 masking and optional write forwarding
//   readReg/stored in, readData out; forwarding ports exist only with REG_FILE_BYPASS_EN
module reg_file_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] readReg,
  input  logic [DATA_W-1:0] stored,
`ifdef REG_FILE_BYPASS_EN
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
`endif
  output logic [DATA_W-1:0] readData
);
`ifdef REG_FILE_BYPASS_EN
  logic hit;
  assign hit = !reset && regWrite && writeReg != '0 && writeReg == readReg;
  assign readData = readReg == '0 ? '0 : hit ? writeData : stored;
`else
  assign readData = readReg == '0 ? '0 : stored;
`endif
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32-entry register file, two async read ports, one sync write port, $0 hardwired to zero
//   in: clk, reset (sync, active-high), readReg1/2, writeReg, writeData, regWrite
//   out: readData1/2, writeCount (saturating count of committed non-$0 writes)
//   REG_FILE_BYPASS_EN: forward writeData to a matching read port in the write cycle
module reg_file_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(cpu_pkg::SP_INIT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              regWrite,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [15:0]       writeCount
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= i == int'(REG_SP) ? SP_INIT : i == int'(REG_ZERO) ? '0 : RESET_VAL;
      writeCount <= '0;
    end else if (regWrite && writeReg != '0) begin
      regs[writeReg] <= writeData;
      writeCount <= writeCount + 16'(writeCount != 16'hFFFF);
    end
  end
  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rdPort1 (
    .readReg(readReg1),
    .stored(regs[readReg1]),
`ifdef REG_FILE_BYPASS_EN
    .reset(reset),
    .regWrite(regWrite),
    .writeReg(writeReg),
    .writeData(writeData),
`endif
    .readData(readData1)
  );
  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rdPort2 (
    .readReg(readReg2),
    .stored(regs[readReg2]),
`ifdef REG_FILE_BYPASS_EN
    .reset(reset),
    .regWrite(regWrite),
    .writeReg(writeReg),
    .writeData(writeData),
`endif
    .readData(readData2)
  );
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed self-checking bench for reg_file_wb
module tb_reg_file_wb;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] readReg1, readReg2, writeReg;
  logic [31:0] writeData, readData1, readData2;
  logic regWrite;
  logic [15:0] writeCount;
  int checks = 0;
  int errors = 0;
  reg_file_wb dut (
    .clk(clk),
    .reset(reset),
    .readReg1(readReg1),
    .readReg2(readReg2),
    .writeReg(writeReg),
    .writeData(writeData),
    .regWrite(regWrite),
    .readData1(readData1),
    .readData2(readData2),
    .writeCount(writeCount)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    writeReg = idx;
    writeData = data;
    regWrite = 1'b1;
    tick();
    regWrite = 1'b0;
  endtask
  logic [31:0] sameCycleExp;
  initial begin
`ifdef REG_FILE_BYPASS_EN
    sameCycleExp = 32'h22;
`else
    sameCycleExp = 32'h11;
`endif
    reset = 1'b1;
    regWrite = 1'b0;
    writeReg = '0;
    writeData = '0;
    readReg1 = '0;
    readReg2 = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1_%0d", i), readData1, i == 29 ? 32'h0000_03FC : 32'h0);
      check($sformatf("rst_rd2_%0d", 31 - i), readData2, 31 - i == 29 ? 32'h0000_03FC : 32'h0);
    end
    check("rst_cnt", 32'(writeCount), 32'h0);
    wr(5'd8, 32'hDEADBEEF);
    readReg1 = 5'd8;
    readReg2 = 5'd9;
    #1;
    check("wr8_rd1", readData1, 32'hDEADBEEF);
    check("wr8_rd2_9", readData2, 32'h0);
    check("wr8_cnt", 32'(writeCount), 32'h1);
    writeReg = 5'd0;
    writeData = 32'hFFFFFFFF;
    regWrite = 1'b1;
    readReg1 = 5'd0;
    #1;
    check("r0_same_cycle", readData1, 32'h0);
    tick();
    regWrite = 1'b0;
    #1;
    check("r0_after", readData1, 32'h0);
    check("r0_cnt", 32'(writeCount), 32'h1);
    wr(5'd5, 32'h11);
    writeReg = 5'd5;
    writeData = 32'h22;
    regWrite = 1'b1;
    readReg1 = 5'd5;
    readReg2 = 5'd5;
    #1;
    check("same_rd1_pre", readData1, sameCycleExp);
    check("same_rd2_pre", readData2, sameCycleExp);
    tick();
    regWrite = 1'b0;
    #1;
    check("same_rd1_post", readData1, 32'h22);
    check("same_cnt", 32'(writeCount), 32'h3);
    writeReg = 5'd5;
    writeData = 32'h99;
    tick();
    check("nowr_hold", readData1, 32'h22);
    check("nowr_cnt", 32'(writeCount), 32'h3);
    wr(5'd3, 32'h5555);
    reset = 1'b1;
    writeReg = 5'd3;
    writeData = 32'hABCD;
    regWrite = 1'b1;
    readReg1 = 5'd3;
    #1;
    check("rstpri_nobypass", readData1, 32'h5555);
    tick();
    reset = 1'b0;
    regWrite = 1'b0;
    readReg2 = 5'd8;
    #1;
    check("rstpri_r3", readData1, 32'h0);
    check("rstpri_r8", readData2, 32'h0);
    check("rstpri_cnt", 32'(writeCount), 32'h0);
    readReg2 = 5'd29;
    #1;
    check("rstpri_sp", readData2, 32'h0000_03FC);
    wr(5'd4, 32'h7);
    readReg1 = 5'd4;
    #1;
    check("postrst_wr", readData1, 32'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      wr(5'd1, 32'(i));
      if (i == 65533) check("sat_fffe", 32'(writeCount), 32'hFFFE);
      if (i == 65534) check("sat_ffff", 32'(writeCount), 32'hFFFF);
    end
    readReg1 = 5'd1;
    #1;
    check("sat_hold", 32'(writeCount), 32'hFFFF);
    check("sat_r1", readData1, 32'h0001_0003);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
